if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0000, meaning the instruction written into IF/ID on flush/bubble.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-006 redirect  input  1  taken branch/jump from a later stage.
REQ-007 redirect_pc  input  32  target byte address for redirect.
REQ-008 halt_req  input  1  single-cycle pulse from decode (syscall halt).
REQ-009 resume  input  1  single-cycle pulse (go button) leaving halted state.
REQ-010 ins_addr  output  10  word address to instruction ROM, combinationally equal to pc[11:2].
REQ-011 ins_data  input  32  instruction word returned combinationally by ROM for ins_addr.
REQ-012 pc  output  32  current fetch PC.
REQ-013 id_ins  output  32  IF/ID instruction register.
REQ-014 id_pc4  output  32  IF/ID register holding fetch PC + 4.
REQ-015 id_valid  output  1  IF/ID holds a real instruction.
REQ-016 halted  output  1  high while state is HALTED.
REQ-017 fetch_count  output  32  number of instructions written valid into IF/ID.

Function
REQ-018 The block SHALL implement a two-state FSM: RUN and HALTED.
REQ-019 In RUN with no stall/redirect, each cycle SHALL load id_ins<=ins_data, id_pc4<=pc+4, id_valid<=1, pc<=pc+4, fetch_count+=1.
REQ-020 Fetch latency SHALL be one cycle: instruction at pc appears on id_ins the edge after pc is presented.
REQ-021 Priority SHALL be rst > redirect > halt_req > stall > normal fetch.
REQ-022 redirect (in either state) SHALL load pc<=redirect_pc with bits [1:0] forced to 0, write id_ins<=NOP_WORD, id_valid<=0, and leave fetch_count unchanged.
REQ-023 redirect asserted together with stall SHALL still redirect and flush; stall is ignored that cycle.
REQ-024 redirect in HALTED SHALL update pc and flush but SHALL NOT leave HALTED.
REQ-025 halt_req in RUN (no redirect) SHALL move to HALTED, hold pc, write NOP_WORD with id_valid<=0.
REQ-026 In HALTED, pc SHALL hold and IF/ID SHALL hold NOP_WORD/id_valid=0 each cycle; halt_req ignored.
REQ-027 resume in HALTED SHALL return to RUN the next edge; fetch resumes the following cycle from the held pc; resume in RUN SHALL be ignored.
REQ-028 stall in RUN (no redirect/halt_req) SHALL hold pc, id_ins, id_pc4, id_valid and fetch_count.
REQ-029 pc+4 SHALL wrap modulo 2^32; ins_addr SHALL wrap within the 4 KB window by taking pc[11:2] only.
REQ-030 fetch_count SHALL wrap modulo 2^32 without flagging.

Reset
REQ-031 On rst, next edge: pc=RESET_PC, id_ins=NOP_WORD, id_pc4=0, id_valid=0, fetch_count=0, state=RUN, halted=0.
REQ-032 rst asserted mid-stall, mid-redirect or in HALTED SHALL override all inputs that cycle.
REQ-033 No state element SHALL rely on initial values; all are reset-loaded.

Structure
REQ-034 RESET_PC default, NOP_WORD default and the RUN/HALTED state encoding SHALL live in the shared CPU constants package.
REQ-035 The PC register with increment/redirect logic SHALL be a sub-module named pc_reg; the IF/ID register, FSM and counter stay in if_stage.
REQ-036 The block SHALL contain no memory; it connects to the existing instruction ROM through ins_addr/ins_data only.

Verification
REQ-037 Reset then 4 free cycles with ROM words 0x11,0x22,0x33,0x44 -> id_ins 0x11..0x44 in order, id_pc4 4,8,12,16, fetch_count=4.
REQ-038 Stall held 3 cycles at pc=0x8 -> pc, id_ins, fetch_count unchanged for 3 cycles, fetch continues at 0x8's successor.
REQ-039 redirect with redirect_pc=0x0000_0103 and stall=1 -> pc=0x100, id_valid=0, id_ins=NOP_WORD, next cycle fetches word 0x40.
REQ-040 halt_req at pc=0x20 -> halted=1, pc stays 0x20 for 10 cycles; resume -> halted=0, then id_ins = ROM[8].
REQ-041 pc=0x0000_0FFC free-run -> ins_addr 0x3FF then 0x000 with pc=0x1000; pc=0xFFFF_FFFC -> pc=0 next.
REQ-042 rst asserted while HALTED with stall=1 -> pc=RESET_PC, state RUN, all outputs at reset values.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared CPU constants for the instruction fetch stage
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } if_state_e;

  // What the IF/ID register does on the coming edge.
  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_HOLD  = 2'd1,
    OP_FLUSH = 2'd2
  } if_op_e;

  // Redirect targets are word aligned: low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// rtl/if_stage_pc_reg.sv - program counter register with increment and redirect
//
// Purpose: holds the fetch PC. Priority: rst > redirect > advance > hold.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   advance        step pc by 4 (wraps modulo 2^32)
//   redirect       load word-aligned redirect_pc
//   redirect_pc    redirect target byte address
//   pc             current PC
//   pc_plus4       combinational pc + 4
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_word(redirect_pc);
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register and halt FSM
//
// Purpose: presents pc to the instruction ROM, captures the returned word
// into IF/ID one edge later, and handles stall, redirect, halt and resume.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             hold pc and IF/ID (RUN only)
//   redirect          flush and load redirect_pc (either state)
//   redirect_pc       redirect target byte address
//   halt_req          enter HALTED from RUN
//   resume            leave HALTED
//   ins_addr          ROM word address, pc[11:2]
//   ins_data          ROM word for ins_addr
//   pc                current fetch PC
//   id_ins, id_pc4    IF/ID instruction and fetch PC + 4
//   id_valid          IF/ID holds a real instruction
//   halted            state is HALTED
//   fetch_count       number of valid IF/ID writes (wraps)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [9:0]  ins_addr,
  input  logic [31:0] ins_data,
  output logic [31:0] pc,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  if_state_e   state;
  if_state_e   state_next;
  if_op_e      op;
  logic [31:0] pc_plus4;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .advance     (op == OP_FETCH),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // The 4 KB ROM window wraps because only pc[11:2] is presented.
  assign ins_addr = pc[11:2];
  assign halted   = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Redirect flushes but never changes state; resume is only honoured when
  // no redirect is present, and the resume cycle itself does not fetch.
  always_comb begin
    state_next = state;
    op         = OP_HOLD;
    if (redirect) begin
      op = OP_FLUSH;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (halt_req) begin
            state_next = ST_HALTED;
            op         = OP_FLUSH;
          end else if (stall) begin
            op = OP_HOLD;
          end else begin
            op = OP_FETCH;
          end
        end
        ST_HALTED: begin
          op = OP_FLUSH;
          if (resume) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_RUN;
          op         = OP_FLUSH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ins      <= NOP_WORD;
      id_pc4      <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      unique case (op)
        OP_FETCH: begin
          id_ins      <= ins_data;
          id_pc4      <= pc_plus4;
          id_valid    <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end
        OP_FLUSH: begin
          id_ins   <= NOP_WORD;
          id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [9:0]  ins_addr;
  logic [31:0] ins_data;
  logic [31:0] pc;
  logic [31:0] id_ins;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ins_data = rom[ins_addr];

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .ins_addr    (ins_addr),
    .ins_data    (ins_data),
    .pc          (pc),
    .id_ins      (id_ins),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 | i;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    halt_req = 1'b0; resume = 1'b0;
    @(negedge clk);
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_id_ins", id_ins, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ins_addr", {22'd0, ins_addr}, 32'd0);

    // Free run: four fetches
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("run_id_ins", id_ins, rom[k]);
      chk("run_id_pc4", id_pc4, 32'(4 * (k + 1)));
      chk("run_valid", {31'd0, id_valid}, 32'd1);
      chk("run_count", fetch_count, 32'(k + 1));
    end
    chk("run_pc", pc, 32'h10);

    // Stall at pc=0x8
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    chk("pre_stall_pc", pc, 32'h8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", pc, 32'h8);
      chk("stall_id_ins", id_ins, 32'h22);
      chk("stall_id_pc4", id_pc4, 32'h8);
      chk("stall_count", fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    chk("post_stall_id_ins", id_ins, 32'h33);
    chk("post_stall_pc", pc, 32'hC);
    chk("post_stall_count", fetch_count, 32'd3);

    // Redirect with stall: redirect wins, low bits dropped
    redirect = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
    step();
    chk("redir_pc", pc, 32'h100);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_id_ins", id_ins, 32'h0);
    chk("redir_count", fetch_count, 32'd3);
    chk("redir_ins_addr", {22'd0, ins_addr}, 32'h40);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("redir_fetch_ins", id_ins, 32'hA000_0040);
    chk("redir_fetch_pc4", id_pc4, 32'h104);
    chk("redir_fetch_count", fetch_count, 32'd4);

    // Halt at pc=0x20
    redirect = 1'b1; redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    chk("halt_pre_pc", pc, 32'h20);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, id_valid}, 32'd0);
    chk("halt_id_ins", id_ins, 32'h0);
    for (int k = 0; k < 10; k++) begin
      halt_req = (k == 3);
      step();
      chk("halted_pc", pc, 32'h20);
      chk("halted_flag", {31'd0, halted}, 32'd1);
      chk("halted_valid", {31'd0, id_valid}, 32'd0);
    end
    halt_req = 1'b0;

    // Redirect while halted moves pc but stays halted
    redirect = 1'b1; redirect_pc = 32'h31;
    step();
    chk("hredir_pc", pc, 32'h30);
    chk("hredir_halted", {31'd0, halted}, 32'd1);
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    chk("hredir_back_pc", pc, 32'h20);
    chk("hredir_count", fetch_count, 32'd4);

    // Resume: no fetch on the resume edge, fetch from held pc next
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_pc", pc, 32'h20);
    chk("resume_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("resume_fetch_ins", id_ins, 32'hA000_0008);
    chk("resume_fetch_pc", pc, 32'h24);
    chk("resume_fetch_count", fetch_count, 32'd5);

    // Resume in RUN is ignored
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("run_resume_halted", {31'd0, halted}, 32'd0);
    chk("run_resume_pc", pc, 32'h28);

    // 4 KB window wrap and 32-bit pc wrap
    redirect = 1'b1; redirect_pc = 32'h0000_0FFC;
    step();
    redirect = 1'b0;
    chk("win_ins_addr_hi", {22'd0, ins_addr}, 32'h3FF);
    step();
    chk("win_id_ins", id_ins, 32'hA000_03FF);
    chk("win_pc", pc, 32'h1000);
    chk("win_ins_addr_lo", {22'd0, ins_addr}, 32'h0);
    chk("win_count", fetch_count, 32'd7);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_id_pc4", id_pc4, 32'h0);
    chk("wrap_id_ins", id_ins, 32'hA000_03FF);

    // Reset while halted with stall
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("pre_rst_halted", {31'd0, halted}, 32'd1);
    stall = 1'b1; rst = 1'b1;
    step();
    chk("hrst_pc", pc, 32'h0);
    chk("hrst_halted", {31'd0, halted}, 32'd0);
    chk("hrst_valid", {31'd0, id_valid}, 32'd0);
    chk("hrst_id_ins", id_ins, 32'h0);
    chk("hrst_id_pc4", id_pc4, 32'h0);
    chk("hrst_count", fetch_count, 32'd0);
    rst = 1'b0; stall = 1'b0;
    step();
    chk("hrst_fetch_ins", id_ins, 32'h11);
    chk("hrst_fetch_count", fetch_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
